// File: rtl/eip_redirect_ctrl_if.sv
// Bundle of writeback/decode/interrupt inputs and EIP/flush outputs of the
// EIP redirect controller. The controller uses the slave modport; the
// environment (writeback, decode, fetch, interrupt source) uses master.
interface eip_redirect_ctrl_if;
  // writeback stage
  logic        r_V_wb;
  logic        r_wb_eip_change;
  logic        r_wb_cond_wr_CF;
  logic        r_wb_cond_wr_ZF;
  logic        r_wb_CF_expected;
  logic        r_wb_ZF_expected;
  logic        w_wb_flag_CF;
  logic        w_wb_flag_ZF;
  logic [31:0] r_wb_alu_res1;
  logic [31:0] r_wb_alu_res3;
  logic        r_wb_wr_eip_alu_res_sel;
  logic        r_wb_pr_size_over;
  // decode / fetch
  logic        r_V_de;
  logic        w_not_stall_fe;
  logic [31:0] w_de_EIP_next;
  // interrupt
  logic        i_int_req;
  logic        o_int_ack;
  // controller outputs
  logic [31:0] r_EIP;
  logic        o_flush_fe;
  logic        o_flush_de;
  logic        o_redirect;
  logic [1:0]  o_state;

  modport master (
    output r_V_wb, r_wb_eip_change, r_wb_cond_wr_CF, r_wb_cond_wr_ZF,
           r_wb_CF_expected, r_wb_ZF_expected, w_wb_flag_CF, w_wb_flag_ZF,
           r_wb_alu_res1, r_wb_alu_res3, r_wb_wr_eip_alu_res_sel,
           r_wb_pr_size_over, r_V_de, w_not_stall_fe, w_de_EIP_next,
           i_int_req,
    input  o_int_ack, r_EIP, o_flush_fe, o_flush_de, o_redirect, o_state
  );

  modport slave (
    input  r_V_wb, r_wb_eip_change, r_wb_cond_wr_CF, r_wb_cond_wr_ZF,
           r_wb_CF_expected, r_wb_ZF_expected, w_wb_flag_CF, w_wb_flag_ZF,
           r_wb_alu_res1, r_wb_alu_res3, r_wb_wr_eip_alu_res_sel,
           r_wb_pr_size_over, r_V_de, w_not_stall_fe, w_de_EIP_next,
           i_int_req,
    output o_int_ack, r_EIP, o_flush_fe, o_flush_de, o_redirect, o_state
  );
endinterface

// File: rtl/eip_redirect_ctrl.sv
// Architectural EIP sequencer: arbitrates writeback redirects, interrupt
// entry and decode sequential advance, and runs a fixed-length fetch/decode
// flush window after every redirect.
// Optional macro EIP_REDIRECT_STATS_EN adds saturating redirect and
// flush-cycle counters as extra output ports.
module eip_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  eip_redirect_ctrl_if.slave bus
`ifdef EIP_REDIRECT_STATS_EN
  ,
  output logic [15:0]        o_stat_redirects,
  output logic [15:0]        o_stat_flush_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_INT   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] eip, eip_nxt;
  logic        redirect_q, redirect_nxt;
  logic        int_ack_q, int_ack_nxt;

  logic        cf_met, zf_met, take_br, take_int, seq_adv;
  logic [31:0] tgt_raw, tgt;
  logic        flush;

  // Redirect qualification, target selection and 16-bit truncation
  always_comb begin
    cf_met   = ~(bus.w_wb_flag_CF ^ bus.r_wb_CF_expected) | ~bus.r_wb_cond_wr_CF;
    zf_met   = ~(bus.w_wb_flag_ZF ^ bus.r_wb_ZF_expected) | ~bus.r_wb_cond_wr_ZF;
    take_br  = bus.r_V_wb & bus.r_wb_eip_change & cf_met & zf_met;
    take_int = bus.i_int_req & ~bus.r_V_wb;
    seq_adv  = bus.r_V_de & bus.w_not_stall_fe;
    tgt_raw  = bus.r_wb_wr_eip_alu_res_sel ? bus.r_wb_alu_res3 : bus.r_wb_alu_res1;
    tgt      = bus.r_wb_pr_size_over ? {16'h0000, tgt_raw[15:0]} : tgt_raw;
  end

  // Next-state, next-EIP and pulse decisions
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    eip_nxt      = eip;
    redirect_nxt = 1'b0;
    int_ack_nxt  = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (take_br) begin
          eip_nxt      = tgt;
          redirect_nxt = 1'b1;
          cnt_nxt      = CNT_INIT;
          state_nxt    = ST_FLUSH;
        end else if (take_int) begin
          eip_nxt      = INT_VECTOR;
          redirect_nxt = 1'b1;
          int_ack_nxt  = 1'b1;
          state_nxt    = ST_INT;
        end else if (seq_adv) begin
          eip_nxt = bus.w_de_EIP_next;
        end
      end
      ST_FLUSH: begin
        // a new redirect restarts the full window; interrupts wait for RUN
        if (take_br) begin
          eip_nxt      = tgt;
          redirect_nxt = 1'b1;
          cnt_nxt      = CNT_INIT;
        end else if (cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_INT: begin
        // the INT cycle is itself a flush cycle, so interrupt entry flushes
        // one cycle longer than a plain redirect
        if (take_br) begin
          eip_nxt      = tgt;
          redirect_nxt = 1'b1;
        end
        cnt_nxt   = CNT_INIT;
        state_nxt = ST_FLUSH;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_RUN;
      end
    endcase
  end

  // State, EIP and registered pulse outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      cnt        <= '0;
      eip        <= RESET_VECTOR;
      redirect_q <= 1'b0;
      int_ack_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      eip        <= eip_nxt;
      redirect_q <= redirect_nxt;
      int_ack_q  <= int_ack_nxt;
    end
  end

  assign flush          = (state != ST_RUN);
  assign bus.r_EIP      = eip;
  assign bus.o_flush_fe = flush;
  assign bus.o_flush_de = flush;
  assign bus.o_redirect = redirect_q;
  assign bus.o_int_ack  = int_ack_q;
  assign bus.o_state    = state;

`ifdef EIP_REDIRECT_STATS_EN
  // Saturating event counters for redirects and flush cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_stat_redirects    <= '0;
      o_stat_flush_cycles <= '0;
    end else begin
      if (redirect_q && (o_stat_redirects != '1))
        o_stat_redirects <= o_stat_redirects + 16'd1;
      if (flush && (o_stat_flush_cycles != '1))
        o_stat_flush_cycles <= o_stat_flush_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eip_redirect_ctrl.sv
// Bench for eip_redirect_ctrl: directed scenarios followed by randomized
// traffic, checked against a cycle-level reference model that tracks the
// remaining flush length as a plain integer.
module tb_eip_redirect_ctrl;
  localparam logic [31:0] RST_V = 32'hFFFF_FFF0;
  localparam logic [31:0] INT_V = 32'h0000_0100;
  localparam int          FC    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eip_redirect_ctrl_if bus();

`ifdef EIP_REDIRECT_STATS_EN
  logic [15:0] stat_red, stat_fl;
`endif

  eip_redirect_ctrl #(
    .RESET_VECTOR(RST_V),
    .INT_VECTOR(INT_V),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef EIP_REDIRECT_STATS_EN
    ,
    .o_stat_redirects(stat_red),
    .o_stat_flush_cycles(stat_fl)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [31:0] m_eip;
  int          m_left;      // flush cycles still to be shown, 0 = running
  bit          m_int_cycle; // current cycle is the interrupt-entry cycle
  bit          m_redirect;
  bit          m_ack;
  int          m_stat_red;
  int          m_stat_fl;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit          cf_ok, zf_ok, br, busy;
    logic [31:0] tgt;
    if (!rst_n) begin
      m_eip = RST_V; m_left = 0; m_int_cycle = 0;
      m_redirect = 0; m_ack = 0; m_stat_red = 0; m_stat_fl = 0;
    end else begin
      if (m_redirect && m_stat_red < 65535) m_stat_red++;
      if (m_left > 0 && m_stat_fl < 65535) m_stat_fl++;
      cf_ok = (bus.w_wb_flag_CF == bus.r_wb_CF_expected) || !bus.r_wb_cond_wr_CF;
      zf_ok = (bus.w_wb_flag_ZF == bus.r_wb_ZF_expected) || !bus.r_wb_cond_wr_ZF;
      br    = bus.r_V_wb && bus.r_wb_eip_change && cf_ok && zf_ok;
      tgt   = bus.r_wb_wr_eip_alu_res_sel ? bus.r_wb_alu_res3 : bus.r_wb_alu_res1;
      if (bus.r_wb_pr_size_over) tgt = tgt & 32'h0000_FFFF;
      busy = (m_left > 0);
      m_redirect = 0; m_ack = 0; m_int_cycle = 0;
      if (br) begin
        m_eip = tgt; m_redirect = 1; m_left = FC;
      end else if (!busy && bus.i_int_req && !bus.r_V_wb) begin
        m_eip = INT_V; m_redirect = 1; m_ack = 1; m_left = FC + 1; m_int_cycle = 1;
      end else if (busy) begin
        m_left--;
      end else if (bus.r_V_de && bus.w_not_stall_fe) begin
        m_eip = bus.w_de_EIP_next;
      end
    end
  endtask

  task automatic step();
    logic [1:0] exp_state;
    @(posedge clk);
    model_update();
    #1;
    exp_state = (m_left == 0) ? 2'd0 : (m_int_cycle ? 2'd2 : 2'd1);
    check_val("eip",      bus.r_EIP,      m_eip);
    check_val("state",    32'(bus.o_state), 32'(exp_state));
    check_val("flush_fe", 32'(bus.o_flush_fe), 32'(m_left > 0));
    check_val("flush_de", 32'(bus.o_flush_de), 32'(m_left > 0));
    check_val("redirect", 32'(bus.o_redirect), 32'(m_redirect));
    check_val("int_ack",  32'(bus.o_int_ack),  32'(m_ack));
`ifdef EIP_REDIRECT_STATS_EN
    check_val("stat_red", 32'(stat_red), 32'(m_stat_red));
    check_val("stat_fl",  32'(stat_fl),  32'(m_stat_fl));
`endif
  endtask

  task automatic idle_inputs();
    bus.r_V_wb = 0; bus.r_wb_eip_change = 0;
    bus.r_wb_cond_wr_CF = 0; bus.r_wb_cond_wr_ZF = 0;
    bus.r_wb_CF_expected = 0; bus.r_wb_ZF_expected = 0;
    bus.w_wb_flag_CF = 0; bus.w_wb_flag_ZF = 0;
    bus.r_wb_alu_res1 = '0; bus.r_wb_alu_res3 = '0;
    bus.r_wb_wr_eip_alu_res_sel = 0; bus.r_wb_pr_size_over = 0;
    bus.r_V_de = 0; bus.w_not_stall_fe = 0; bus.w_de_EIP_next = '0;
    bus.i_int_req = 0;
  endtask

  task automatic random_inputs();
    rst_n = ($urandom_range(0, 59) != 0);
    bus.r_V_wb = ($urandom_range(0, 3) == 0);
    bus.r_wb_eip_change = $urandom_range(0, 1) != 0;
    bus.r_wb_cond_wr_CF = $urandom_range(0, 1) != 0;
    bus.r_wb_cond_wr_ZF = $urandom_range(0, 1) != 0;
    bus.r_wb_CF_expected = $urandom_range(0, 1) != 0;
    bus.r_wb_ZF_expected = $urandom_range(0, 1) != 0;
    bus.w_wb_flag_CF = $urandom_range(0, 1) != 0;
    bus.w_wb_flag_ZF = $urandom_range(0, 1) != 0;
    bus.r_wb_alu_res1 = $urandom;
    bus.r_wb_alu_res3 = $urandom;
    bus.r_wb_wr_eip_alu_res_sel = $urandom_range(0, 1) != 0;
    bus.r_wb_pr_size_over = ($urandom_range(0, 3) == 0);
    bus.r_V_de = ($urandom_range(0, 3) != 0);
    bus.w_not_stall_fe = ($urandom_range(0, 3) != 0);
    bus.w_de_EIP_next = $urandom;
    if ($urandom_range(0, 9) == 0) bus.i_int_req = ~bus.i_int_req;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    // reset held two cycles
    step(); step();
    check_val("rst_eip", bus.r_EIP, 32'hFFFF_FFF0);

    // sequential advance, then stall holds
    rst_n = 1;
    bus.r_V_de = 1; bus.w_not_stall_fe = 1; bus.w_de_EIP_next = 32'h1004;
    step();
    check_val("seq_eip", bus.r_EIP, 32'h1004);
    bus.w_not_stall_fe = 0; bus.w_de_EIP_next = 32'h2222;
    step();
    check_val("stall_eip", bus.r_EIP, 32'h1004);

    // CF-qualified branch taken: two flush cycles
    bus.r_V_de = 0;
    bus.r_V_wb = 1; bus.r_wb_eip_change = 1; bus.r_wb_cond_wr_CF = 1;
    bus.r_wb_CF_expected = 1; bus.w_wb_flag_CF = 1; bus.r_wb_alu_res1 = 32'h2000;
    step();
    check_val("br_eip", bus.r_EIP, 32'h2000);
    check_val("br_pulse", 32'(bus.o_redirect), 32'd1);
    bus.r_V_wb = 0;
    step(); step();
    check_val("br_flush_end", 32'(bus.o_flush_fe), 32'd0);

    // CF not met: falls through to sequential advance
    bus.r_V_wb = 1; bus.w_wb_flag_CF = 0;
    bus.r_V_de = 1; bus.w_not_stall_fe = 1; bus.w_de_EIP_next = 32'h3000;
    step();
    check_val("nobr_eip", bus.r_EIP, 32'h3000);

    // 16-bit operand-size truncation of alu_res3
    bus.r_wb_cond_wr_CF = 0; bus.r_V_de = 0;
    bus.r_wb_alu_res3 = 32'hABCD_1234; bus.r_wb_wr_eip_alu_res_sel = 1;
    bus.r_wb_pr_size_over = 1;
    step();
    check_val("trunc_eip", bus.r_EIP, 32'h0000_1234);
    idle_inputs();
    step(); step();

    // branch and interrupt together: branch first, interrupt after flush
    bus.i_int_req = 1;
    bus.r_V_wb = 1; bus.r_wb_eip_change = 1; bus.r_wb_alu_res1 = 32'h5000;
    step();
    check_val("bri_eip", bus.r_EIP, 32'h5000);
    bus.r_V_wb = 0;
    step(); step(); step();
    check_val("int_eip", bus.r_EIP, 32'h0000_0100);
    check_val("int_ack", 32'(bus.o_int_ack), 32'd1);
    bus.i_int_req = 0;
    step(); step(); step();
    check_val("int_flush_end", 32'(bus.o_flush_fe), 32'd0);

    // reset during the second flush cycle
    bus.r_V_wb = 1; bus.r_wb_eip_change = 1; bus.r_wb_alu_res1 = 32'h6000;
    step();
    bus.r_V_wb = 0;
    step();
    rst_n = 0;
    step();
    check_val("midrst_state", 32'(bus.o_state), 32'd0);
    check_val("midrst_eip", bus.r_EIP, 32'hFFFF_FFF0);
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
